// File: rtl/axi4_localbus_bridge.sv
// ---------------------------------------------------------------------------
// axi4_localbus_bridge
//   AXI4 slave that turns each 64-bit beat into up to two 32-bit local-bus
//   accesses (lower dword first, then upper dword). Bursts are fully
//   serialized, one channel at a time. Every local access carries an ack
//   timeout so a missing register never stalls the host.
//
// Ports
//   sys_clk, sys_rstn    clock, asynchronous active-low reset
//   s_axi_aw* / s_axi_w* / s_axi_b*   AXI4 write address, data, response
//   s_axi_ar* / s_axi_r*              AXI4 read address, data
//   lb_addr, lb_wdata    local dword address and write data
//   lb_write, lb_read    one-cycle access strobes
//   lb_rdata, lb_ack     local read data, one-cycle acknowledge
//   busy                 FSM is serving a transaction
// ---------------------------------------------------------------------------
module axi4_localbus_bridge #(
  parameter int          ID_W         = 4,
  parameter int          LB_AW        = 16,
  parameter int          ACK_TIMEOUT  = 64,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [63:0]       s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [63:0]       s_axi_wdata,
  input  logic [7:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [63:0]       s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [63:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [LB_AW-1:0]  lb_addr,
  output logic [31:0]       lb_wdata,
  output logic              lb_write,
  output logic              lb_read,
  input  logic [31:0]       lb_rdata,
  input  logic              lb_ack,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, W_DATA, W_LO, W_HI, W_RESP, R_LO, R_HI, R_DATA} state_t;

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam int AW = LB_AW + 2;   // byte-address bits that reach the local bus

  state_t          state;
  logic            wr_prio;        // write wins the next AW/AR tie
  logic [ID_W-1:0] id_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      len_q, beat_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic [63:0]     wdata_q;
  logic [7:0]      wstrb_q;
  logic            err_q;          // sticky error for the write burst / read beat
  logic [CW-1:0]   tmr_q;          // cycles elapsed since the pending strobe

  logic [AW-1:0]    addr_nxt;
  logic [LB_AW-1:0] lo_addr, hi_addr, nxt_lo_addr;
  logic             last_beat, strobe_q, acc_wait, acc_done, w_hs;
  logic             err_nxt, w_beat_done;
  logic [31:0]      rd_val;
  logic             unused_bits;

  // FIXED bursts re-use the beat address; INCR and WRAP both step by size.
  assign addr_nxt    = (burst_q == 2'b00) ? addr_q : addr_q + (AW'(1) << size_q);
  assign lo_addr     = {addr_q[AW-1:3], 1'b0};
  assign hi_addr     = {addr_q[AW-1:3], 1'b1};
  assign nxt_lo_addr = {addr_nxt[AW-1:3], 1'b0};
  assign last_beat   = (beat_q == len_q);
  assign strobe_q    = lb_write | lb_read;
  assign acc_wait    = (state == W_LO) || (state == W_HI) || (state == R_LO) || (state == R_HI);
  // An ack coincident with the strobe itself is not a response.
  assign acc_done    = acc_wait && !strobe_q && (lb_ack || tmr_q == CW'(ACK_TIMEOUT));
  assign rd_val      = lb_ack ? lb_rdata : TIMEOUT_DATA;
  assign w_hs        = s_axi_wready && s_axi_wvalid;
  assign err_nxt     = err_q | (w_hs && (s_axi_wlast != last_beat)) | (acc_done && !lb_ack);
  assign w_beat_done = (state == W_DATA && w_hs && s_axi_wstrb == 8'h00) ||
                       (state == W_LO && acc_done && wstrb_q[7:4] == 4'h0) ||
                       (state == W_HI && acc_done);

  assign s_axi_bid   = id_q;
  assign s_axi_rid   = id_q;
  assign busy        = (state != IDLE);
  assign unused_bits = ^{s_axi_awaddr[63:AW], s_axi_araddr[63:AW]};

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state         <= IDLE;
      wr_prio       <= 1'b1;
      id_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      err_q         <= 1'b0;
      tmr_q         <= '0;
      s_axi_awready <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= 2'b00;
      s_axi_rlast   <= 1'b0;
      lb_addr       <= '0;
      lb_wdata      <= '0;
      lb_write      <= 1'b0;
      lb_read       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so a later
      // assignment in this block overrides an earlier one for the same edge;
      // the strobes rely on that to stay exactly one cycle wide.
      lb_write <= 1'b0;
      lb_read  <= 1'b0;
      if (acc_wait) tmr_q <= strobe_q ? CW'(1) : tmr_q + CW'(1);

      case (state)
        IDLE: begin
          if (s_axi_awready) begin
            s_axi_awready <= 1'b0;
            id_q          <= s_axi_awid;
            addr_q        <= s_axi_awaddr[AW-1:0];
            len_q         <= s_axi_awlen;
            size_q        <= s_axi_awsize;
            burst_q       <= s_axi_awburst;
            beat_q        <= '0;
            err_q         <= 1'b0;
            s_axi_wready  <= 1'b1;
            state         <= W_DATA;
          end else if (s_axi_arready) begin
            s_axi_arready <= 1'b0;
            id_q          <= s_axi_arid;
            addr_q        <= s_axi_araddr[AW-1:0];
            len_q         <= s_axi_arlen;
            size_q        <= s_axi_arsize;
            burst_q       <= s_axi_arburst;
            beat_q        <= '0;
            err_q         <= 1'b0;
            lb_read       <= 1'b1;
            lb_addr       <= {s_axi_araddr[AW-1:3], 1'b0};
            state         <= R_LO;
          end else if (s_axi_awvalid && (wr_prio || !s_axi_arvalid)) begin
            s_axi_awready <= 1'b1;
            wr_prio       <= 1'b0;
          end else if (s_axi_arvalid) begin
            s_axi_arready <= 1'b1;
            wr_prio       <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            s_axi_wready <= 1'b0;
            wdata_q      <= s_axi_wdata;
            wstrb_q      <= s_axi_wstrb;
            err_q        <= err_nxt;
            // No byte enables on the local bus: any lane set writes the dword.
            if (|s_axi_wstrb[3:0]) begin
              lb_write <= 1'b1;
              lb_addr  <= lo_addr;
              lb_wdata <= s_axi_wdata[31:0];
              state    <= W_LO;
            end else if (|s_axi_wstrb[7:4]) begin
              lb_write <= 1'b1;
              lb_addr  <= hi_addr;
              lb_wdata <= s_axi_wdata[63:32];
              state    <= W_HI;
            end
          end
        end
        W_LO: begin
          if (acc_done) begin
            err_q <= err_nxt;
            if (|wstrb_q[7:4]) begin
              lb_write <= 1'b1;
              lb_addr  <= hi_addr;
              lb_wdata <= wdata_q[63:32];
              state    <= W_HI;
            end
          end
        end
        W_HI: begin
          if (acc_done) err_q <= err_nxt;
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= IDLE;
          end
        end
        R_LO: begin
          if (acc_done) begin
            s_axi_rdata[31:0] <= rd_val;
            err_q             <= err_nxt;
            lb_read           <= 1'b1;
            lb_addr           <= hi_addr;
            state             <= R_HI;
          end
        end
        R_HI: begin
          if (acc_done) begin
            s_axi_rdata[63:32] <= rd_val;
            s_axi_rresp        <= err_nxt ? 2'b10 : 2'b00;
            s_axi_rlast        <= last_beat;
            s_axi_rvalid       <= 1'b1;
            state              <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
            if (last_beat) begin
              state <= IDLE;
            end else begin
              addr_q  <= addr_nxt;
              beat_q  <= beat_q + 8'd1;
              err_q   <= 1'b0;
              lb_read <= 1'b1;
              lb_addr <= nxt_lo_addr;
              state   <= R_LO;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Beat count, not wlast, ends the write burst.
      if (w_beat_done) begin
        if (last_beat) begin
          s_axi_bvalid <= 1'b1;
          s_axi_bresp  <= err_nxt ? 2'b10 : 2'b00;
          state        <= W_RESP;
        end else begin
          addr_q       <= addr_nxt;
          beat_q       <= beat_q + 8'd1;
          s_axi_wready <= 1'b1;
          state        <= W_DATA;
        end
      end
    end
  end

endmodule
